// File: rtl/tm1638_key_scanner_pkg.sv
// Shared types and helpers for the TM1638 key scanner: FSM states, key vectors, event record.
// Also holds the read-word-to-key mapping and the lowest-pending-key priority pick.
package tm1638_key_scanner_pkg;

    localparam int KEY_COUNT = 8;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, UPDATE, EMIT} scan_state_t;
    typedef logic [7:0] keys_t;
    typedef logic [2:0] key_index_t;

    typedef struct packed {
        logic       press;
        key_index_t key;
    } key_event_t;

    // Byte k of the burst carries key k in bit 0 and key k+4 in bit 4.
    function automatic keys_t keys_from_word(input logic [31:0] word);
        keys_t k;
        for (int i = 0; i < 4; i++) begin
            k[i]     = word[8*i];
            k[i + 4] = word[8*i + 4];
        end
        return k;
    endfunction

    function automatic key_index_t lowest_key(input keys_t pend);
        key_index_t idx;
        idx = '0;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (pend[i]) idx = key_index_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tm1638_key_scanner_if.sv
// Scanner bundle: scan request/ack, read word, event stream and diagnostics.
// master = scanner side, slave = driver/consumer side.
interface tm1638_key_scanner_if;
    import tm1638_key_scanner_pkg::*;

    logic        scan_req;
    logic        scan_ack;
    logic [31:0] read_data;
    logic        read_valid;
    keys_t       keys;
    logic        event_valid;
    logic        event_ready;
    logic        event_press;
    key_index_t  event_key;
    scan_state_t diag_state;
    logic        diag_timeout;

    modport master (
        output scan_req, keys, event_valid, event_press, event_key, diag_state, diag_timeout,
        input  scan_ack, read_data, read_valid, event_ready
    );

    modport slave (
        input  scan_req, keys, event_valid, event_press, event_key, diag_state, diag_timeout,
        output scan_ack, read_data, read_valid, event_ready
    );
endinterface

// File: rtl/tm1638_key_scanner_debounce.sv
// Per-key debouncer: flips stable after DEBOUNCE_SAMPLES differing update strobes; change pulses with the strobe.
// TM1638_KEYS_AUTOREPEAT_EN adds a held-scan counter that re-pulses change every REPEAT_SCANS pressed updates.
module tm1638_key_debounce #(
    parameter int DEBOUNCE_SAMPLES = 3
`ifdef TM1638_KEYS_AUTOREPEAT_EN
    , parameter int REPEAT_SCANS = 20
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic update,
    input  logic sample,
    output logic stable,
    output logic change
);
    logic [3:0] cnt;
    logic       flip;

    assign flip = update && (sample != stable) && (cnt == 4'(DEBOUNCE_SAMPLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (update) begin
            if (sample != stable) begin
                if (flip) begin
                    stable <= ~stable;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

`ifdef TM1638_KEYS_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_SCANS + 1);
    logic [HW-1:0] held;
    logic          rpt;

    // The update that debounces a press starts the count; it does not count as a held scan.
    assign rpt = update && stable && !flip && (held == HW'(REPEAT_SCANS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= '0;
        end else if (update) begin
            if (flip || !stable || rpt) held <= '0;
            else                        held <= held + 1'b1;
        end
    end

    assign change = flip | rpt;
`else
    assign change = flip;
`endif

endmodule

// File: rtl/tm1638_key_scanner.sv
// Periodic TM1638 key scanner: request burst, capture word, debounce 8 keys, stream press/release events.
// Events drain lowest index first; a stalled consumer holds the FSM in EMIT (option: TM1638_KEYS_AUTOREPEAT_EN).
module tm1638_key_scanner
    import tm1638_key_scanner_pkg::*;
#(
    parameter int SCAN_PERIOD_CYCLES = 1000,
    parameter int DEBOUNCE_SAMPLES   = 3,
    parameter int READ_WIDTH         = 32,
    parameter int TIMEOUT_CYCLES     = 4096
`ifdef TM1638_KEYS_AUTOREPEAT_EN
    , parameter int REPEAT_SCANS     = 20
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    tm1638_key_scanner_if.master bus
);
    localparam int PW  = $clog2(SCAN_PERIOD_CYCLES);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam int TMW = (PW > TW) ? PW : TW;

    scan_state_t           state, next_state;
    logic [TMW-1:0]        timer;
    logic [READ_WIDTH-1:0] word;
    keys_t                 sample_keys, stable, change, pending, remaining;
    key_event_t            evt;
    logic                  event_valid, scan_req, diag_timeout;
    logic                  period_done, wait_expired, accept, update_stb;

    assign period_done  = (state == IDLE) && (timer == TMW'(SCAN_PERIOD_CYCLES - 1));
    assign wait_expired = (state == WAIT_DATA) && !bus.read_valid && (timer == TMW'(TIMEOUT_CYCLES - 1));
    assign accept       = event_valid && bus.event_ready;
    assign remaining    = pending & ~(keys_t'(1) << evt.key);
    assign update_stb   = (state == UPDATE);
    assign sample_keys  = keys_from_word(word);

    for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
        tm1638_key_debounce #(
            .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
`ifdef TM1638_KEYS_AUTOREPEAT_EN
            , .REPEAT_SCANS(REPEAT_SCANS)
`endif
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .update (update_stb),
            .sample (sample_keys[k]),
            .stable (stable[k]),
            .change (change[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (period_done) next_state = REQ;
            REQ:       if (bus.scan_ack) next_state = WAIT_DATA;
            WAIT_DATA: begin
                if (bus.read_valid)     next_state = UPDATE;
                else if (wait_expired)  next_state = IDLE;
            end
            UPDATE:    next_state = (|change) ? EMIT : IDLE;
            EMIT:      if (accept && (remaining == '0)) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer        <= '0;
            scan_req     <= 1'b0;
            diag_timeout <= 1'b0;
            word         <= '0;
            pending      <= '0;
            event_valid  <= 1'b0;
            evt          <= '0;
        end else begin
            timer        <= (next_state != state) ? '0 : timer + 1'b1;
            scan_req     <= (next_state == REQ);
            diag_timeout <= wait_expired;
            if ((state == WAIT_DATA) && bus.read_valid) word <= bus.read_data;
            if (state == UPDATE)  pending <= change;
            else if (accept)      pending <= remaining;
            // Press/release is read from the stable state, which is frozen while in EMIT.
            if (state == EMIT) begin
                if (!event_valid) begin
                    event_valid <= 1'b1;
                    evt.key     <= lowest_key(pending);
                    evt.press   <= stable[lowest_key(pending)];
                end else if (accept) begin
                    event_valid <= |remaining;
                    evt.key     <= lowest_key(remaining);
                    evt.press   <= stable[lowest_key(remaining)];
                end
            end
        end
    end

    assign bus.scan_req     = scan_req;
    assign bus.keys         = stable;
    assign bus.event_valid  = event_valid;
    assign bus.event_press  = evt.press;
    assign bus.event_key    = evt.key;
    assign bus.diag_state   = state;
    assign bus.diag_timeout = diag_timeout;

endmodule
